bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_pkg.sv | 20 ++
 rtl/rr_pick.sv | 26 ++
 rtl/bus_arbiter.sv | 130 +++++++++++++
 tb/tb_bus_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions: default widths, arbiter FSM states and index sizing helper.
package bus_pkg;

  localparam int unsigned BUS_ADDR_W = 10;
  localparam int unsigned BUS_DATA_W = 8;
  localparam int unsigned OWNER_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  // Bits needed to index n requesters (at least one).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request searching upward from last+1 with wrap-around.
module rr_pick
  import bus_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]        req,
  input  logic [idx_w(N_REQ)-1:0] last,
  output logic                    valid,
  output logic [idx_w(N_REQ)-1:0] idx
);

  localparam int unsigned SEL_W = idx_w(N_REQ);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      if (!valid && req[SEL_W'((32'(last) + i) % N_REQ)]) begin
        valid = 1'b1;
        idx   = SEL_W'((32'(last) + i) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter giving N_REQ cores fixed-latency access to one synchronous RAM port.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ADDR_W = BUS_ADDR_W,
  parameter int unsigned DATA_W = BUS_DATA_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           grant_request,
  input  logic [N_REQ-1:0]           rw,
  input  logic [N_REQ*ADDR_W-1:0]    address,
  input  logic [N_REQ*DATA_W-1:0]    data_out,
  output logic [N_REQ-1:0]           grant_given,
  output logic [DATA_W-1:0]          data_in,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       busy,
  output logic [OWNER_W-1:0]         owner
);

  localparam int unsigned SEL_W = idx_w(N_REQ);

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     owner_q, owner_d;
  logic [SEL_W-1:0]     last_q, last_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [DATA_W-1:0]    data_in_q, data_in_d;
  logic                 mem_en_q, mem_en_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic                 busy_q, busy_d;

  logic                 pick_valid;
  logic [SEL_W-1:0]     pick_idx;
  logic [ADDR_W-1:0]    core_addr  [N_REQ];
  logic [DATA_W-1:0]    core_wdata [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_core
    assign core_addr[g]  = address[g*ADDR_W +: ADDR_W];
    assign core_wdata[g] = data_out[g*DATA_W +: DATA_W];
  end

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req   (grant_request),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // The mem_* registers double as the latch of the winner's request, so core-side
  // changes after the arbitration edge never reach the RAM. grant and data_in are
  // registered at the GRANT edge, when the RAM read data from ACCESS is valid.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    grant_d     = '0;
    data_in_d   = '0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d     = ST_ACCESS;
          owner_d     = pick_idx;
          last_d      = pick_idx;
          mem_en_d    = 1'b1;
          mem_we_d    = rw[pick_idx];
          mem_addr_d  = core_addr[pick_idx];
          mem_wdata_d = core_wdata[pick_idx];
        end
      end
      ST_ACCESS: state_d = ST_GRANT;
      ST_GRANT: begin
        state_d   = ST_RELEASE;
        grant_d   = N_REQ'(1) << owner_q;
        data_in_d = mem_rdata;
      end
      ST_RELEASE: begin
        if (!grant_request[owner_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      last_q      <= SEL_W'(N_REQ - 1);
      grant_q     <= '0;
      data_in_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      data_in_q   <= data_in_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign grant_given = grant_q;
  assign data_in     = data_in_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign busy        = busy_q;
  assign owner       = OWNER_W'(owner_q);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a synchronous RAM model on the memory port.
module tb_bus_arbiter;
  import bus_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = BUS_ADDR_W;
  localparam int unsigned DW = BUS_DATA_W;

  logic              clk;
  logic              reset;
  logic [N-1:0]      grant_request, rw, grant_given;
  logic [N*AW-1:0]   address;
  logic [N*DW-1:0]   data_out;
  logic [DW-1:0]     data_in, mem_wdata, mem_rdata;
  logic              mem_en, mem_we, busy;
  logic [AW-1:0]     mem_addr;
  logic [2:0]        owner;

  logic [DW-1:0]     mem [0:(1<<AW)-1];
  logic              pl_en;
  logic [AW-1:0]     pl_addr;
  logic [DW-1:0]     pl_data;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  bus_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .grant_request (grant_request),
    .rw            (rw),
    .address       (address),
    .data_out      (data_out),
    .grant_given   (grant_given),
    .data_in       (data_in),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .busy          (busy),
    .owner         (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: read data valid the cycle after mem_en; bench preload port has priority.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic set_core(input int c, input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rw[c] = r;
    address[c*AW +: AW] = a;
    data_out[c*DW +: DW] = d;
  endtask

  // Waits (bounded) for a grant pulse; checks who got it and how many edges it took.
  task automatic wait_grant(input int exp_idx, input int exp_lat, input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (grant_given == '0 && n < 12);
    check({tag, "_who"}, 32'(grant_given), 32'(1) << exp_idx);
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
  endtask

  initial begin
    reset = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    grant_request = '0; rw = '0; address = '0; data_out = '0;

    preload(10'h000, 8'h00);
    preload(10'h005, 8'hA7);
    preload(10'h010, 8'h00);
    preload(10'h055, 8'h11);
    preload(10'h123, 8'h5A);
    check("rst_grant", 32'(grant_given), 32'h0);
    check("rst_mem_en", 32'(mem_en), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_data_in", 32'(data_in), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    reset = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 32'h0);

    // Single read by core0.
    set_core(0, 1'b0, 10'h005, 8'h00);
    grant_request = 4'b0001;
    tick();
    check("rd_mem_en", 32'(mem_en), 32'h1);
    check("rd_mem_we", 32'(mem_we), 32'h0);
    check("rd_mem_addr", 32'(mem_addr), 32'h005);
    check("rd_owner", 32'(owner), 32'h0);
    check("rd_busy", 32'(busy), 32'h1);
    tick();
    check("rd_mem_en_1cyc", 32'(mem_en), 32'h0);
    check("rd_no_early_grant", 32'(grant_given), 32'h0);
    tick();
    check("rd_grant", 32'(grant_given), 32'h1);
    check("rd_data", 32'(data_in), 32'hA7);
    grant_request = 4'b0000;
    tick();
    check("rd_grant_1cyc", 32'(grant_given), 32'h0);
    check("rd_back_idle", 32'(busy), 32'h0);

    // Core1 writes 0x3C to 0x3FF, then reads it back.
    set_core(1, 1'b1, 10'h3FF, 8'h3C);
    grant_request = 4'b0010;
    tick();
    check("wr_mem_we", 32'(mem_we), 32'h1);
    check("wr_mem_addr", 32'(mem_addr), 32'h3FF);
    check("wr_mem_wdata", 32'(mem_wdata), 32'h3C);
    check("wr_owner", 32'(owner), 32'h1);
    tick();
    check("wr_mem_we_1cyc", 32'(mem_we), 32'h0);
    tick();
    check("wr_grant", 32'(grant_given), 32'h2);
    grant_request = 4'b0000;
    tick();
    set_core(1, 1'b0, 10'h3FF, 8'h00);
    grant_request = 4'b0010;
    wait_grant(1, 3, "rbw");
    check("rbw_data", 32'(data_in), 32'h3C);
    grant_request = 4'b0000;
    tick();

    // Fairness: all four request continuously after a fresh reset.
    reset = 1'b0;
    #2;
    reset = 1'b1;
    for (int c = 0; c < 4; c++) set_core(c, 1'b0, 10'h000, 8'h00);
    grant_request = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      wait_grant(i % 4, 3, "rr");
      grant_request[i % 4] = 1'b0;
      tick();
      check("rr_idle_gap", 32'(busy), 32'h0);
      grant_request[i % 4] = 1'b1;
    end
    grant_request = 4'b0000;
    tick();
    tick();

    // Hold: core2 changes address and drops its request during ACCESS.
    set_core(2, 1'b0, 10'h123, 8'h00);
    grant_request = 4'b0100;
    tick();
    check("hold_owner", 32'(owner), 32'h2);
    check("hold_addr0", 32'(mem_addr), 32'h123);
    set_core(2, 1'b1, 10'h055, 8'hFF);
    grant_request = 4'b0000;
    #3;
    check("hold_addr1", 32'(mem_addr), 32'h123);
    check("hold_we", 32'(mem_we), 32'h0);
    wait_grant(2, 2, "hold");
    check("hold_data", 32'(data_in), 32'h5A);
    tick();
    check("hold_idle", 32'(busy), 32'h0);

    // Reset during ACCESS of a core3 write aborts it; core0 then wins first.
    set_core(0, 1'b0, 10'h005, 8'h00);
    set_core(1, 1'b0, 10'h000, 8'h00);
    set_core(3, 1'b1, 10'h010, 8'h77);
    grant_request = 4'b1011;
    tick();
    check("ra_owner", 32'(owner), 32'h3);
    check("ra_mem_en", 32'(mem_en), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("ra_mem_en0", 32'(mem_en), 32'h0);
    check("ra_mem_we0", 32'(mem_we), 32'h0);
    check("ra_mem_addr0", 32'(mem_addr), 32'h0);
    check("ra_wdata0", 32'(mem_wdata), 32'h0);
    check("ra_busy0", 32'(busy), 32'h0);
    check("ra_owner0", 32'(owner), 32'h0);
    tick();
    check("ra_no_grant_a", 32'(grant_given), 32'h0);
    tick();
    check("ra_no_grant_b", 32'(grant_given), 32'h0);
    check("ra_write_lost", 32'(mem[10'h010]), 32'h0);
    reset = 1'b1;
    wait_grant(0, 3, "ra_first");
    check("ra_first_data", 32'(data_in), 32'hA7);
    grant_request = 4'b0000;
    tick();

    // Release: core3 holds its request after the grant; core1 waits behind it.
    set_core(3, 1'b0, 10'h005, 8'h00);
    grant_request = 4'b1000;
    wait_grant(3, 3, "rel");
    grant_request[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rel_no_grant", 32'(grant_given), 32'h0);
      check("rel_busy", 32'(busy), 32'h1);
      check("rel_no_mem_en", 32'(mem_en), 32'h0);
    end
    grant_request[3] = 1'b0;
    wait_grant(1, 4, "rel_next");
    grant_request = 4'b0000;
    tick();
    tick();
    check("end_idle", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
